// File: rtl/ha_array_accumulator.sv
// ---------------------------------------------------------------------------
// ha_array_accumulator
//
// Final summation stage for the unsigned 8x8 approximate multiplier. Takes the
// four compressed row pairs from the half-adder-array front end, reduces them
// in a two-stage pipeline and presents the 16-bit approximate product with a
// valid/ready handshake. Throughput is one beat per cycle; latency is 2 cycles.
//
// Parameters
//   SATURATE : 1 = clamp sums above 16'hFFFF to 16'hFFFF, 0 = keep low 16 bits
//   CNT_W    : width of the accepted-beat counter
//
// Ports
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   in_valid / in_ready input handshake (in_ready is combinational)
//   ha_array_k_b        7-bit carry vector of array k (k = 0..3)
//   ha_array_k_t        9-bit sum vector of array k
//   out_valid/out_ready output handshake
//   product             16-bit approximate product (held while stalled)
//   sat                 sum exceeded 16 bits (clamped or wrapped)
//   txn_cnt             accepted input beats, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module ha_array_accumulator #(
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      product,
  output logic             sat,
  output logic [CNT_W-1:0] txn_cnt
);

  // Gather the row vectors so the per-row and per-pair arithmetic can be
  // generated uniformly.
  logic [8:0]  t_vec [4];
  logic [6:0]  b_vec [4];
  logic [9:0]  row   [4];

  assign t_vec[0] = ha_array_0_t;
  assign t_vec[1] = ha_array_1_t;
  assign t_vec[2] = ha_array_2_t;
  assign t_vec[3] = ha_array_3_t;
  assign b_vec[0] = ha_array_0_b;
  assign b_vec[1] = ha_array_1_b;
  assign b_vec[2] = ha_array_2_b;
  assign b_vec[3] = ha_array_3_b;

  // Carry bit b[i] has weight i+2 relative to the row base.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_row
      assign row[gi] = {1'b0, t_vec[gi]} + {1'b0, b_vec[gi], 2'b00};
    end
  endgenerate

  // Pair sums. A row peaks at 1019, so row + (row << 2) peaks at 5095 and
  // needs 13 bits to avoid losing the top carry on all-ones inputs.
  logic [12:0] pair_next [2];

  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      assign pair_next[gi] = {3'b000, row[2*gi]} + {1'b0, row[2*gi+1], 2'b00};
    end
  endgenerate

  // Handshake: each stage advances when it is empty or its consumer moves.
  logic s1_v_reg;
  logic s2_v_reg;
  logic s1_adv;
  logic s2_adv;

  assign s2_adv   = !s2_v_reg || out_ready;
  assign s1_adv   = !s1_v_reg || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: registered pair sums.
  logic [12:0] pair_reg [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        pair_reg[i] <= '0;
      end
    end else if (s1_adv) begin
      s1_v_reg <= in_valid;
      for (int i = 0; i < 2; i++) begin
        pair_reg[i] <= pair_next[i];
      end
    end
  end

  // Stage 2: final 17-bit sum, then clamp or wrap into 16 bits.
  logic [16:0] sum17;
  logic        over;
  logic [15:0] product_next;
  logic [15:0] product_reg;
  logic        sat_reg;

  assign sum17        = {4'b0000, pair_reg[0]} + {pair_reg[1], 4'b0000};
  assign over         = sum17[16];
  assign product_next = (SATURATE && over) ? 16'hFFFF : sum17[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_reg    <= 1'b0;
      product_reg <= '0;
      sat_reg     <= 1'b0;
    end else if (s2_adv) begin
      s2_v_reg    <= s1_v_reg;
      product_reg <= product_next;
      sat_reg     <= over;
    end
  end

  assign out_valid = s2_v_reg;
  assign product   = product_reg;
  assign sat       = sat_reg;

  // Accepted-beat counter, naturally wraps at 2^CNT_W.
  logic [CNT_W-1:0] txn_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_cnt_reg <= '0;
    end else if (in_valid && s1_adv) begin
      txn_cnt_reg <= txn_cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign txn_cnt = txn_cnt_reg;

endmodule

// File: tb/tb_ha_array_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ha_array_accumulator
//
// Drives two instances in lockstep: one clamping (SATURATE=1, 16-bit counter)
// and one wrapping (SATURATE=0, 3-bit counter so counter wrap is exercised).
// Expected products come from a weighted sum of the raw row vectors; a queue
// of accepted beats tracks order, latency and occupancy.
// ---------------------------------------------------------------------------
module tb_ha_array_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [8:0]  t_in [4];
  logic [6:0]  b_in [4];

  logic        in_ready,   out_valid,   sat;
  logic [15:0] product,    txn_cnt;
  logic        in_ready_w, out_valid_w, sat_w;
  logic [15:0] product_w;
  logic [2:0]  txn_cnt_w;

  always #5 clk = ~clk;

  ha_array_accumulator #(.SATURATE(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]),
    .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
    .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]),
    .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .sat(sat), .txn_cnt(txn_cnt)
  );

  ha_array_accumulator #(.SATURATE(1'b0), .CNT_W(3)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .ha_array_0_b(b_in[0]), .ha_array_1_b(b_in[1]),
    .ha_array_2_b(b_in[2]), .ha_array_3_b(b_in[3]),
    .ha_array_0_t(t_in[0]), .ha_array_1_t(t_in[1]),
    .ha_array_2_t(t_in[2]), .ha_array_3_t(t_in[3]),
    .out_valid(out_valid_w), .out_ready(out_ready), .product(product_w),
    .sat(sat_w), .txn_cnt(txn_cnt_w)
  );

  typedef struct packed {
    logic [16:0] sum;
    int          tag;
  } beat_t;

  typedef struct packed {
    logic [3:0][8:0] t;
    logic [3:0][6:0] b;
    logic [15:0]     p_sat;
    logic [15:0]     p_wrap;
    logic            sat;
  } vec_t;

  beat_t q[$];
  vec_t  tbl [8];
  int    n_err = 0;
  int    n_chk = 0;
  int    edges = 0;
  int    exp_cnt = 0;
  int    n_emit = 0;
  int    first_emit = -1;
  int    last_emit = -1;
  logic  last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: sum_k (t_k + 4*b_k) * 4^k in plain integer arithmetic.
  function automatic logic [16:0] ref_sum();
    int s = 0;
    int w = 1;
    for (int k = 0; k < 4; k++) begin
      s += (int'(t_in[k]) + 4 * int'(b_in[k])) * w;
      w *= 4;
    end
    return s[16:0];
  endfunction

  function automatic logic [15:0] clamp(input logic [16:0] s);
    return (s > 17'd65535) ? 16'hFFFF : s[15:0];
  endfunction

  // One clock cycle: inputs are already driven. Outputs are sampled on the
  // falling edge, the model is updated for the coming rising edge.
  task automatic cycle();
    logic  exp_rdy;
    logic  exp_ov;
    beat_t b;
    @(negedge clk);
    exp_rdy = (q.size() < 2) || out_ready;
    exp_ov  = (q.size() > 0) && (edges - q[0].tag >= 2);
    chk("in_ready",    32'(in_ready),    32'(exp_rdy));
    chk("in_ready_w",  32'(in_ready_w),  32'(exp_rdy));
    chk("out_valid",   32'(out_valid),   32'(exp_ov));
    chk("out_valid_w", 32'(out_valid_w), 32'(exp_ov));
    chk("txn_cnt",     32'(txn_cnt),     32'(exp_cnt % 65536));
    chk("txn_cnt_w",   32'(txn_cnt_w),   32'(exp_cnt % 8));
    if (exp_ov && out_ready) begin
      b = q.pop_front();
      chk("product",   32'(product),   32'(clamp(b.sum)));
      chk("product_w", 32'(product_w), 32'(b.sum[15:0]));
      chk("sat",       32'(sat),       32'(b.sum > 17'd65535));
      chk("sat_w",     32'(sat_w),     32'(b.sum > 17'd65535));
      n_emit++;
      if (first_emit < 0) first_emit = edges;
      last_emit = edges;
    end
    last_acc = in_valid && exp_rdy;
    if (last_acc) begin
      b.sum = ref_sum();
      b.tag = edges;
      q.push_back(b);
      exp_cnt++;
    end
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 4; k++) begin
      t_in[k] = '0;
      b_in[k] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    q.delete();
    exp_cnt = 0;
    chk("rst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("rst_product",   32'(product),   32'(16'h0000));
    chk("rst_sat",       32'(sat),       32'(1'b0));
    chk("rst_txn_cnt",   32'(txn_cnt),   32'(16'h0000));
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bi;
    logic [15:0] hold;
    logic        have;
    logic [8:0]  vals [3];

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    clear_inputs();

    // Directed vectors: single beats with hand-computed expectations.
    for (int i = 0; i < 8; i++) tbl[i] = '0;
    tbl[0].t[0] = 9'h001;  tbl[0].p_sat = 16'h0001; tbl[0].p_wrap = 16'h0001;
    tbl[1].b[0] = 7'h01;   tbl[1].p_sat = 16'd4;    tbl[1].p_wrap = 16'd4;
    tbl[2].t[3] = 9'h001;  tbl[2].p_sat = 16'd64;   tbl[2].p_wrap = 16'd64;
    tbl[3].b[3] = 7'h40;   tbl[3].p_sat = 16'd16384; tbl[3].p_wrap = 16'd16384;
    tbl[4].t[1] = 9'h100;  tbl[4].p_sat = 16'd1024; tbl[4].p_wrap = 16'd1024;
    for (int k = 0; k < 4; k++) begin
      tbl[5].t[k] = 9'h1FF;
      tbl[5].b[k] = 7'h7F;
    end
    tbl[5].p_sat = 16'hFFFF; tbl[5].p_wrap = 16'h5257; tbl[5].sat = 1'b1;
    // Exactly 65536: first value that overflows.
    tbl[6].t[3] = 9'h1FF; tbl[6].b[3] = 7'h7F; tbl[6].t[2] = 9'd20;
    tbl[6].p_sat = 16'hFFFF; tbl[6].p_wrap = 16'h0000; tbl[6].sat = 1'b1;
    // Exactly 65535: largest value that fits.
    tbl[7].t[3] = 9'h1FF; tbl[7].b[3] = 7'h7F; tbl[7].t[2] = 9'd19; tbl[7].t[0] = 9'd15;
    tbl[7].p_sat = 16'hFFFF; tbl[7].p_wrap = 16'hFFFF; tbl[7].sat = 1'b0;

    do_reset();

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) begin
        t_in[k] = tbl[i].t[k];
        b_in[k] = tbl[i].b[k];
      end
      in_valid = 1'b1;
      out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
        t_in[k] = 9'($urandom);
        b_in[k] = 7'($urandom);
      end
      chk("lat1_out_valid", 32'(out_valid), 32'(1'b0));
      cycle();
      chk("lat2_out_valid", 32'(out_valid), 32'(1'b1));
      chk("vec_product",    32'(product),   32'(tbl[i].p_sat));
      chk("vec_product_w",  32'(product_w), 32'(tbl[i].p_wrap));
      chk("vec_sat",        32'(sat),       32'(tbl[i].sat));
      chk("vec_sat_w",      32'(sat_w),     32'(tbl[i].sat));
      if (i == 0) chk("vec0_txn_cnt", 32'(txn_cnt), 32'd1);
      cycle();
    end

    // Back-to-back stream of 8 beats.
    do_reset();
    out_ready = 1'b1;
    n_emit = 0;
    first_emit = -1;
    last_emit = -1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      t_in[0] = 9'(c + 1);
      cycle();
    end
    chk("stream_emits",  32'(n_emit), 32'd8);
    chk("stream_span",   32'(last_emit - first_emit), 32'd7);
    chk("stream_txn",    32'(txn_cnt), 32'd8);
    chk("stream_txn_w",  32'(txn_cnt_w), 32'd0);

    // Backpressure: 3 beats offered, only 2 fit while the output is stalled.
    do_reset();
    vals[0] = 9'd11; vals[1] = 9'd12; vals[2] = 9'd13;
    bi = 0;
    have = 1'b0;
    hold = '0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (bi < 3);
      t_in[0] = vals[bi % 3];
      cycle();
      if (last_acc) bi++;
      if (out_valid) begin
        if (!have) begin
          hold = product;
          have = 1'b1;
        end else begin
          chk("bp_stable", 32'(product), 32'(hold));
        end
      end
    end
    chk("bp_accepted", 32'(bi), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'(1'b0));
    chk("bp_head",     32'(product), 32'd11);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && (bi < 3 || q.size() > 0); c++) begin
      in_valid = (bi < 3);
      t_in[0] = vals[bi % 3];
      cycle();
      if (last_acc) bi++;
    end
    chk("bp_all_accepted", 32'(bi), 32'd3);
    chk("bp_drained",      32'(q.size()), 32'd0);

    // Reset asserted while two beats are in flight.
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    t_in[0] = 9'd5;
    cycle();
    t_in[0] = 9'd6;
    cycle();
    in_valid = 1'b0;
    chk("pre_rst_product", 32'(product), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(1'b0));
    chk("arst_product",   32'(product),   32'(16'h0000));
    chk("arst_txn_cnt",   32'(txn_cnt),   32'(16'h0000));
    chk("arst_sat",       32'(sat),       32'(1'b0));
    q.delete();
    exp_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();

    // Randomized traffic against the queue model.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          t_in[k] = 9'h1FF;
          b_in[k] = 7'h7F;
        end else begin
          t_in[k] = 9'($urandom);
          b_in[k] = 7'($urandom);
        end
      end
      cycle();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    chk("rand_drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
